// File: rtl/turn_throw_ctrl_pkg.sv
// Shared types and sprite-index encodings for the per-turn throw controller.
package turn_pkg;

    typedef enum logic [1:0] {
        T_IDLE,
        T_CHARGE,
        T_THROW,
        T_DONE
    } turn_state_t;

    localparam logic [1:0] IDX_IDLE  = 2'd0;
    localparam logic [1:0] IDX_DRAW  = 2'd1;
    localparam logic [1:0] IDX_THROW = 2'd2;

endpackage

// File: rtl/turn_throw_ctrl_power_meter.sv
// Throw power meter: a prescaler that steps a saturating or ping-pong power value
// once every TICKS enabled cycles; the step can be suppressed with freeze.
module power_meter #(
    parameter int TICKS    = 1_015_625,
    parameter int PWR_W    = 6,
    parameter bit PINGPONG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             freeze,
    output logic [PWR_W-1:0] power
);

    localparam int               PRE_W    = $clog2(TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS - 1);
    localparam logic [PWR_W-1:0] PWR_MAX  = '1;

    logic [PRE_W-1:0] prescaler;
    logic             going_down;
    logic [PWR_W-1:0] power_d;
    logic             going_down_d;
    logic             wrap;

    assign wrap = (prescaler == PRE_LAST);

    // Value the meter moves to on the next step; applied only on a prescaler wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which is what would otherwise infer a latch.
        power_d      = power;
        going_down_d = going_down;
        if (!PINGPONG) begin
            if (power != PWR_MAX) power_d = power + PWR_W'(1);
        end else if (going_down) begin
            if (power == '0) begin
                going_down_d = 1'b0;
                power_d      = PWR_W'(1);
            end else begin
                power_d = power - PWR_W'(1);
            end
        end else begin
            if (power == PWR_MAX) begin
                going_down_d = 1'b1;
                power_d      = PWR_MAX - PWR_W'(1);
            end else begin
                power_d = power + PWR_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            power      <= '0;
            going_down <= 1'b0;
        end else if (clr) begin
            prescaler  <= '0;
            power      <= '0;
            going_down <= 1'b0;
        end else if (en) begin
            prescaler <= wrap ? '0 : prescaler + PRE_W'(1);
            if (wrap && !freeze) begin
                power      <= power_d;
                going_down <= going_down_d;
            end
        end
    end

endmodule

// File: rtl/turn_throw_ctrl.sv
// Per-turn throw controller: edge-qualified SPACE press charges a power meter,
// release launches a fixed-length throw window, and losing the turn aborts cleanly.
module turn_throw_ctrl
    import turn_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int CHARGE_TICKS = 1_015_625,
    parameter int THROW_TICKS  = 65_000_000,
    parameter int PWR_W        = 6,
    parameter bit PINGPONG     = 1'b0,
    localparam int PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   space,
    input  logic [NUM_PLAYERS-1:0] turn_active,
    output logic                   enable_draw,
    output logic [1:0]             index,
    output logic [PWR_W-1:0]       power,
    output logic                   throw_enable,
    output logic                   throw_start,
    output logic [PID_W-1:0]       throw_player,
    output logic                   turn_done
);

    localparam int              THR_W      = $clog2(THROW_TICKS);
    localparam logic [THR_W-1:0] THROW_LAST = THR_W'(THROW_TICKS - 1);

    turn_state_t      state, state_d;
    logic             space_q;
    logic [PID_W-1:0] pid_q;
    logic [PID_W-1:0] pid;
    logic             valid_turn;
    logic             press;
    logic             abort;
    logic [THR_W-1:0] throw_cnt;
    logic [PWR_W-1:0] meter_power;

    assign press      = space & ~space_q;
    assign valid_turn = ($countones(turn_active) == 1);
    assign abort      = !valid_turn || (pid != pid_q);

    always_comb begin
        pid = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (turn_active[i]) pid = PID_W'(i);
        end
    end

    // Abort is tested first in CHARGE and THROW so it overrides every other exit.
    always_comb begin
        state_d = state;
        unique case (state)
            T_IDLE:   if (press && valid_turn) state_d = T_CHARGE;
            T_CHARGE: begin
                if (abort)       state_d = T_IDLE;
                else if (!space) state_d = T_THROW;
            end
            T_THROW: begin
                if (abort)                        state_d = T_IDLE;
                else if (throw_cnt == THROW_LAST) state_d = T_DONE;
            end
            T_DONE:   state_d = T_IDLE;
            default:  state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= T_IDLE;
            space_q   <= 1'b0;
            pid_q     <= '0;
            throw_cnt <= '0;
        end else begin
            state   <= state_d;
            space_q <= space;
            if (state == T_IDLE && state_d == T_CHARGE) pid_q <= pid;
            if (state == T_THROW && state_d == T_THROW) throw_cnt <= throw_cnt + THR_W'(1);
            else                                         throw_cnt <= '0;
        end
    end

    // Cleared throughout IDLE so a new charge always starts from zero power and phase;
    // the value is simply held (en low) through THROW.
    power_meter #(
        .TICKS    (CHARGE_TICKS),
        .PWR_W    (PWR_W),
        .PINGPONG (PINGPONG)
    ) u_meter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == T_IDLE),
        .en     (state == T_CHARGE),
        .freeze (~space),
        .power  (meter_power)
    );

    // Outputs decode registered state only, so they change on the same edge as the FSM.
    always_comb begin
        enable_draw  = 1'b0;
        index        = IDX_IDLE;
        power        = '0;
        throw_enable = 1'b0;
        throw_start  = 1'b0;
        throw_player = '0;
        turn_done    = 1'b0;
        unique case (state)
            T_CHARGE: begin
                enable_draw = 1'b1;
                index       = IDX_DRAW;
                power       = meter_power;
            end
            T_THROW: begin
                index        = IDX_THROW;
                power        = meter_power;
                throw_enable = 1'b1;
                throw_start  = (throw_cnt == '0);
                throw_player = pid_q;
            end
            T_DONE:  turn_done = 1'b1;
            default: ;
        endcase
    end

endmodule
